sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised single-clock FIFO for the UART receive path: buffers received bytes between the receiver's byte-strobe and the host-side reader. Generalises the 8-bit fixed-depth buffer with configurable width and depth, an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.

## Interface
Parameters:
- DATA_W, 8, data word width in bits (≥1)
- DEPTH, 16, number of entries; power of two, ≥2
- AFULL_TH, DEPTH-2, ALMOST_FULL asserted when COUNT ≥ AFULL_TH (1..DEPTH)
- AEMPTY_TH, 2, ALMOST_EMPTY asserted when COUNT ≤ AEMPTY_TH (0..DEPTH-1)
- FWFT, 0, 0 = registered standard read; 1 = head word presented without a RD

Ports (AW = log2(DEPTH)):
- Clk  in  1  clock; all logic on rising edge
- Rst  in  1  synchronous, active-high reset; priority over every other input
- EN  in  1  global enable; low freezes all state, RD/WR ignored, no error flagging
- WR  in  1  write request
- dataIn  in  DATA_W  write data, sampled when WR accepted
- RD  in  1  read request
- dataOut  out  DATA_W  read data
- EMPTY  out  1  no readable word
- FULL  out  1  COUNT == DEPTH
- ALMOST_FULL  out  1  COUNT ≥ AFULL_TH
- ALMOST_EMPTY  out  1  COUNT ≤ AEMPTY_TH
- COUNT  out  AW+1  stored words, 0..DEPTH
- OVERFLOW  out  1  sticky: a WR was rejected while FULL
- UNDERFLOW  out  1  sticky: a RD was rejected while EMPTY

## Operation
- Reset values: dataOut 0, EMPTY 1, FULL 0, ALMOST_EMPTY 1, ALMOST_FULL 0, COUNT 0, OVERFLOW 0, UNDERFLOW 0; pointers 0. Memory contents not cleared.
- Write accepted iff EN & WR & (!FULL | read accepted this cycle). Store dataIn at wr_ptr, wr_ptr+1 (wraps modulo DEPTH).
- Read accepted iff EN & RD & !EMPTY. rd_ptr+1 (wraps).
- COUNT next = COUNT + wr_acc − rd_acc; never leaves 0..DEPTH.
- Simultaneous RD & WR: when FULL, both accepted, COUNT stays DEPTH, no overflow. When EMPTY, write accepted, read rejected, UNDERFLOW set.
- Rejected WR while FULL (no accepted read): data dropped, OVERFLOW←1. Rejected RD while EMPTY: UNDERFLOW←1, dataOut unchanged. Flags clear only by Rst.
- FWFT=0: on accepted read, dataOut ← mem[rd_ptr] at that edge; otherwise dataOut holds.
- FWFT=1: dataOut = mem[rd_ptr] continuously while !EMPTY; RD pops it. Value while EMPTY is don't-care (hold last is acceptable).
- All flags and COUNT are registered, computed from next-state COUNT, so they are mutually consistent every cycle.
- Rst mid-operation: next edge returns to reset values; in-flight read or write in that cycle is discarded.

## Timing
- Write-to-visible: word written at edge N raises COUNT / drops EMPTY after edge N.
- FWFT=0 read latency 1: RD asserted during cycle N, data valid after edge N.
- FWFT=1 read latency 0: first word visible on dataOut the cycle after its write edge.
- Full throughput: one write and one read per cycle sustained indefinitely.
- EN low for any number of cycles: all outputs hold.

## Structure
- Shared package/header fifo_pkg: clog2 function, default DATA_W/DEPTH constants reused by the UART receiver top.
- One sub-module: fifo_ram (simple dual-port, DEPTH×DATA_W, sync write, async read; FWFT=0 registers the read output in the parent).
- Parent holds pointers, COUNT, flag registers and acceptance logic.

## Test plan
- DEPTH=4, DATA_W=8, FWFT=0: Rst, write 0x00..0x03 -> FULL=1, COUNT=4, ALMOST_FULL=1 from COUNT=2; read 4 -> dataOut 0x00,0x01,0x02,0x03 one cycle after each RD, EMPTY=1 after last.
- Full + 5th write 0x04 -> OVERFLOW=1, COUNT=4, subsequent reads return 0x00..0x03 (0x04 absent).
- Empty + RD -> UNDERFLOW=1, dataOut unchanged; simultaneous RD&WR on empty with 0xA5 -> COUNT=1, UNDERFLOW=1.
- FULL, RD&WR with 0x55 for 6 cycles -> COUNT stays 4, no OVERFLOW, read order preserved across pointer wrap.
- FWFT=1: write 0x3C -> dataOut=0x3C next cycle with no RD; RD -> EMPTY=1.
- Mid-stream Rst with COUNT=3 and EN toggled low -> all outputs at reset values after edge; EN low holds COUNT and flags.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO constants and helpers, also used by the UART receiver top.
package fifo_pkg;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_DEPTH  = 16;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle between a FIFO and its producer/consumer.
interface sync_fifo_param_if
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH
) ();
   localparam int unsigned AW = clog2(DEPTH);

   logic              EN;
   logic              WR;
   logic [DATA_W-1:0] dataIn;
   logic              RD;
   logic [DATA_W-1:0] dataOut;
   logic              EMPTY;
   logic              FULL;
   logic              ALMOST_FULL;
   logic              ALMOST_EMPTY;
   logic [AW:0]       COUNT;
   logic              OVERFLOW;
   logic              UNDERFLOW;

   modport master (
      output EN, WR, dataIn, RD,
      input  dataOut, EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVERFLOW, UNDERFLOW
   );

   modport slave (
      input  EN, WR, dataIn, RD,
      output dataOut, EMPTY, FULL, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVERFLOW, UNDERFLOW
   );
endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module fifo_ram
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned DEPTH  = DEF_DEPTH,
   parameter int unsigned AW     = clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky errors and
// optional first-word-fall-through read.
module sync_fifo_param
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned DEPTH     = DEF_DEPTH,
   parameter int unsigned AFULL_TH  = DEPTH - 2,
   parameter int unsigned AEMPTY_TH = 2,
   parameter bit          FWFT      = 1'b0
) (
   input logic              Clk,
   input logic              Rst,
   sync_fifo_param_if.slave bus
);
   localparam int unsigned AW = clog2(DEPTH);
   localparam logic [AW:0] depth_c  = DEPTH[AW:0];
   localparam logic [AW:0] afull_c  = AFULL_TH[AW:0];
   localparam logic [AW:0] aempty_c = AEMPTY_TH[AW:0];

   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [AW:0]       count_q, count_d;
   logic              empty_q, full_q, afull_q, aempty_q, ovf_q, unf_q;
   logic              rd_acc, wr_acc;
   logic [DATA_W-1:0] ram_rdata;

   // A read frees a slot in the same cycle, so a full FIFO can still take a write.
   always_comb begin
      rd_acc  = bus.EN & bus.RD & ~empty_q;
      wr_acc  = bus.EN & bus.WR & (~full_q | rd_acc);
      count_d = count_q + {{AW{1'b0}}, wr_acc} - {{AW{1'b0}}, rd_acc};
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         aempty_q <= 1'b1;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else if (bus.EN) begin
         if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_acc) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q  <= count_d;
         empty_q  <= (count_d == '0);
         full_q   <= (count_d == depth_c);
         afull_q  <= (count_d >= afull_c);
         aempty_q <= (count_d <= aempty_c);
         ovf_q    <= ovf_q | (bus.WR & ~wr_acc);
         unf_q    <= unf_q | (bus.RD & ~rd_acc);
      end
   end

   fifo_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AW     (AW)
   ) u_ram (
      .clk   (Clk),
      .we    (wr_acc & ~Rst),
      .waddr (wr_ptr_q),
      .wdata (bus.dataIn),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   generate
      if (FWFT) begin : g_fwft
         assign bus.dataOut = ram_rdata;
      end else begin : g_std
         logic [DATA_W-1:0] dout_q;
         always_ff @(posedge Clk) begin
            if (Rst)         dout_q <= '0;
            else if (rd_acc) dout_q <= ram_rdata;
         end
         assign bus.dataOut = dout_q;
      end
   endgenerate

   assign bus.EMPTY        = empty_q;
   assign bus.FULL         = full_q;
   assign bus.ALMOST_FULL  = afull_q;
   assign bus.ALMOST_EMPTY = aempty_q;
   assign bus.COUNT        = count_q;
   assign bus.OVERFLOW     = ovf_q;
   assign bus.UNDERFLOW    = unf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench: standard and FWFT FIFOs driven in lockstep, checked against a queue model.
module tb_sync_fifo_param;
   localparam int unsigned DW = 8;
   localparam int unsigned DP = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0, wr = 1'b0, rd = 1'b0;
   logic [DW-1:0] din = '0;

   always #5 clk = ~clk;

   sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DP)) if0 ();
   sync_fifo_param_if #(.DATA_W(DW), .DEPTH(DP)) if1 ();

   assign if0.EN = en;  assign if0.WR = wr;  assign if0.RD = rd;  assign if0.dataIn = din;
   assign if1.EN = en;  assign if1.WR = wr;  assign if1.RD = rd;  assign if1.dataIn = din;

   sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(1'b0)) dut0 (
      .Clk (clk), .Rst (rst), .bus (if0.slave)
   );
   sync_fifo_param #(.DATA_W(DW), .DEPTH(DP), .FWFT(1'b1)) dut1 (
      .Clk (clk), .Rst (rst), .bus (if1.slave)
   );

   int passed = 0;
   int total  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Behavioural model: contents as a queue, flags as plain booleans.
   logic [DW-1:0] q[$];
   bit            m_ovf, m_unf, started;
   logic [DW-1:0] m_dout;

   always @(posedge clk) begin
      bit rd_ok, wr_ok;
      if (rst) begin
         q.delete();
         m_ovf = 0; m_unf = 0; m_dout = '0; started = 1;
      end else if (en) begin
         rd_ok = rd && q.size() > 0;
         wr_ok = wr && (q.size() < DP || rd_ok);
         if (rd && !rd_ok) m_unf = 1;
         if (wr && !wr_ok) m_ovf = 1;
         if (rd_ok) m_dout = q.pop_front();
         if (wr_ok) q.push_back(din);
      end
   end

   always @(negedge clk) begin
      int n;
      if (started) begin
         n = q.size();
         chk("count0", 32'(if0.COUNT), 32'(n));
         chk("empty0", 32'(if0.EMPTY), 32'(n == 0));
         chk("full0", 32'(if0.FULL), 32'(n == DP));
         chk("afull0", 32'(if0.ALMOST_FULL), 32'(n >= DP - 2));
         chk("aempty0", 32'(if0.ALMOST_EMPTY), 32'(n <= 2));
         chk("ovf0", 32'(if0.OVERFLOW), 32'(m_ovf));
         chk("unf0", 32'(if0.UNDERFLOW), 32'(m_unf));
         chk("dout0", 32'(if0.dataOut), 32'(m_dout));
         chk("count1", 32'(if1.COUNT), 32'(n));
         chk("empty1", 32'(if1.EMPTY), 32'(n == 0));
         chk("ovf1", 32'(if1.OVERFLOW), 32'(m_ovf));
         chk("unf1", 32'(if1.UNDERFLOW), 32'(m_unf));
         if (n > 0) chk("dout1_head", 32'(if1.dataOut), 32'(q[0]));
      end
   end

   // Apply inputs just after a falling edge, return at the next falling edge.
   task automatic step(input logic r, input logic e, input logic w, input logic d,
                       input logic [DW-1:0] v);
      rst = r; en = e; wr = w; rd = d; din = v;
      @(negedge clk);
   endtask

   initial begin
      logic [DW-1:0] exp_rd [6];
      exp_rd[0] = 8'h10; exp_rd[1] = 8'h11; exp_rd[2] = 8'h12;
      exp_rd[3] = 8'h13; exp_rd[4] = 8'h55; exp_rd[5] = 8'h55;

      @(negedge clk);
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      chk("lit_reset_count", 32'(if0.COUNT), 0);
      chk("lit_reset_empty", 32'(if0.EMPTY), 1);
      chk("lit_reset_aempty", 32'(if0.ALMOST_EMPTY), 1);
      chk("lit_reset_dout", 32'(if0.dataOut), 0);

      for (int i = 0; i < 4; i++) begin
         step(0, 1, 1, 0, 8'(i));
         chk("lit_fill_afull", 32'(if0.ALMOST_FULL), 32'(i >= 1));
      end
      chk("lit_full", 32'(if0.FULL), 1);
      chk("lit_full_count", 32'(if0.COUNT), 4);

      step(0, 1, 1, 0, 8'h04);
      chk("lit_ovf", 32'(if0.OVERFLOW), 1);
      chk("lit_ovf_count", 32'(if0.COUNT), 4);

      for (int i = 0; i < 4; i++) begin
         chk("lit_fwft_head", 32'(if1.dataOut), 32'(i));
         step(0, 1, 0, 1, 0);
         chk("lit_read", 32'(if0.dataOut), 32'(i));
      end
      chk("lit_empty_after", 32'(if0.EMPTY), 1);

      step(0, 1, 0, 1, 0);
      chk("lit_unf", 32'(if0.UNDERFLOW), 1);
      chk("lit_unf_dout_hold", 32'(if0.dataOut), 3);

      step(0, 1, 1, 1, 8'hA5);
      chk("lit_rdwr_empty_count", 32'(if0.COUNT), 1);
      chk("lit_fwft_a5", 32'(if1.dataOut), 32'hA5);
      step(0, 1, 0, 1, 0);
      chk("lit_fwft_pop_empty", 32'(if1.EMPTY), 1);
      chk("lit_read_a5", 32'(if0.dataOut), 32'hA5);

      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 8'(8'h10 + i));
      for (int i = 0; i < 6; i++) begin
         step(0, 1, 1, 1, 8'h55);
         chk("lit_stream_dout", 32'(if0.dataOut), 32'(exp_rd[i]));
         chk("lit_stream_count", 32'(if0.COUNT), 4);
         chk("lit_stream_ovf", 32'(if0.OVERFLOW), 0);
      end

      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 8'(8'h20 + i));
      step(0, 1, 0, 1, 0);
      step(0, 1, 1, 0, 8'h23);
      step(0, 1, 1, 0, 8'h24);
      step(0, 1, 1, 0, 8'h25);
      chk("lit_pre_hold_ovf", 32'(if0.OVERFLOW), 1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 1, 1, 8'hFF);
         chk("lit_en_hold_count", 32'(if0.COUNT), 4);
         chk("lit_en_hold_dout", 32'(if0.dataOut), 32'h20);
      end
      step(0, 1, 0, 1, 0);
      chk("lit_mid_count3", 32'(if0.COUNT), 3);
      step(1, 0, 1, 1, 8'h77);
      chk("lit_rst_count", 32'(if0.COUNT), 0);
      chk("lit_rst_ovf", 32'(if0.OVERFLOW), 0);
      chk("lit_rst_dout", 32'(if0.dataOut), 0);
      chk("lit_rst_full", 32'(if0.FULL), 0);

      for (int c = 0; c < 3000; c++) begin
         int mode, pw, pr;
         mode = (c / 150) % 3;
         pw = (mode == 0) ? 80 : (mode == 1) ? 25 : 55;
         pr = (mode == 0) ? 25 : (mode == 1) ? 80 : 55;
         step(($urandom % 300) == 0, ($urandom % 8) != 0,
              ($urandom % 100) < pw, ($urandom % 100) < pr, 8'($urandom));
      end
      step(0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
